// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and helpers for the CNN datapath blocks.
package cnn_pkg;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_TAPS   = 9;
  localparam int DEF_ACC_W  = 22;
  localparam int DEF_OUT_W  = 9;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered signed multiply with valid and first-beat tag (pipeline stage S1).
module mac_mult_stage
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic                       i_first,
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_prod,
  output logic                       o_valid,
  output logic                       o_first
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_valid;
  logic                     r_first;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

  // Product and tag only load on a real beat so gaps leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_valid <= i_valid & ~i_flush;
      if (i_valid) begin
        r_prod  <= w_prod;
        r_first <= i_first;
      end
    end
  end

  assign o_prod  = r_prod;
  assign o_valid = r_valid;
  assign o_first = r_first;

endmodule

// File: rtl/conv_mac.sv
// Pipelined signed MAC over one kernel window, with shift / ReLU / saturation post-processing.
//   state    | meaning
//   ST_ACCUM | accepting operand beats, counting taps
//   ST_DRAIN | last product in flight into the accumulator
//   ST_HOLD  | window result presented until the consumer takes it
module conv_mac
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     relu_en,
  input  logic                     flush,
  output logic signed [ACC_W-1:0]  result,
  output logic signed [OUT_W-1:0]  q_out,
  output logic                     q_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  mac_state_e               r_state;
  mac_state_e               w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_started;
  logic                     r_relu;
  logic signed [ACC_W-1:0]  r_acc;

  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_s1_prod;
  logic                     w_s1_valid;
  logic                     w_s1_first;
  logic signed [ACC_W-1:0]  w_s1_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [ACC_W-1:0]  w_relu;
  logic signed [OUT_W-1:0]  w_q;
  logic                     w_sat;

  // Derived from state rather than in_ready to keep the FSM comb block acyclic.
  assign w_accept = in_valid & r_started & (r_state == ST_ACCUM) & ~flush;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = r_started;
        if (w_accept && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
    if (flush) w_state_nxt = ST_ACCUM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_ACCUM;
      r_cnt     <= '0;
      r_started <= 1'b0;
      r_relu    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_first) r_relu <= relu_en;
      end
    end
  end

  mac_mult_stage #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_valid (w_accept),
    .i_first (w_first),
    .i_a     (a_in),
    .i_b     (b_in),
    .o_prod  (w_s1_prod),
    .o_valid (w_s1_valid),
    .o_first (w_s1_first)
  );

  assign w_s1_ext = ACC_W'(w_s1_prod);

  // The first-beat tag restarts the sum, so back-to-back windows need no clear cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_s1_valid) begin
      r_acc <= w_s1_first ? w_s1_ext : r_acc + w_s1_ext;
    end
  end

  assign w_shift = r_acc >>> SHIFT;
  assign w_relu  = (r_relu && w_shift[ACC_W-1]) ? '0 : w_shift;

  always_comb begin
    w_q   = w_relu[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_relu > Q_MAX) begin
      w_q   = Q_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_relu < Q_MIN) begin
      w_q   = Q_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  // Outputs read as zero outside HOLD so a partial window is never visible.
  always_comb begin
    result = '0;
    q_out  = '0;
    q_sat  = 1'b0;
    if (out_valid) begin
      result = r_acc;
      q_out  = w_q;
      q_sat  = w_sat;
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Directed, table-driven bench for conv_mac with hand-computed window sums.
module tb_conv_mac;

  localparam int DATA_W = 9;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 22;
  localparam int OUT_W  = 9;

  logic                     clk;
  logic                     reset;
  logic signed [DATA_W-1:0] a_in;
  logic signed [DATA_W-1:0] b_in;
  logic                     in_valid;
  logic                     in_ready;
  logic                     relu_en;
  logic                     flush;
  logic signed [ACC_W-1:0]  result;
  logic signed [OUT_W-1:0]  q_out;
  logic                     q_sat;
  logic                     out_valid;
  logic                     out_ready;

  int checks = 0;
  int errors = 0;

  conv_mac #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W),
    .SHIFT  (0),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .b_in      (b_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .relu_en   (relu_en),
    .flush     (flush),
    .result    (result),
    .q_out     (q_out),
    .q_sat     (q_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     relu;
    bit                       gaps;
    int                       exp_r;
    int                       exp_q;
    logic                     exp_s;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input int a, input int b, input bit relu, input bit gaps,
                              input int r, input int q, input bit s);
    vec_t v;
    v.a     = DATA_W'(a);
    v.b     = DATA_W'(b);
    v.relu  = relu;
    v.gaps  = gaps;
    v.exp_r = r;
    v.exp_q = q;
    v.exp_s = s;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("in_ready_before_beat", in_ready, 1);
  endtask

  // Drives n beats starting at a negedge; relu_en carries the window value only on beat 0.
  task automatic send_beats(input int n, input logic signed [DATA_W-1:0] a,
                            input logic signed [DATA_W-1:0] b, input logic relu, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        a_in     = DATA_W'(77);
        b_in     = DATA_W'(-33);
        cyc();
      end
      a_in     = a;
      b_in     = b;
      relu_en  = (i == 0) ? relu : ~relu;
      in_valid = 1'b1;
      wait_ready();
      cyc();
    end
    in_valid = 1'b0;
    relu_en  = ~relu;
  endtask

  task automatic run_window(input vec_t v, input bit hs);
    send_beats(TAPS, v.a, v.b, v.relu, v.gaps);
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 0);
    cyc();
    check("hold_out_valid", out_valid, 1);
    check("hold_in_ready", in_ready, 0);
    check("result", result, v.exp_r);
    check("q_out", q_out, v.exp_q);
    check("q_sat", q_sat, v.exp_s);
    if (hs) begin
      cyc();
      check("release_out_valid", out_valid, 0);
    end
  endtask

  initial begin
    vec_t v;
    logic signed [ACC_W-1:0] held;

    vecs[0]  = mk(3, 4, 0, 0, 108, 108, 0);
    vecs[1]  = mk(-256, -256, 0, 0, 589824, 255, 1);
    vecs[2]  = mk(-5, 7, 1, 0, -315, 0, 0);
    vecs[3]  = mk(-5, 7, 0, 0, -315, -256, 1);
    vecs[4]  = mk(1, 1, 0, 0, 9, 9, 0);
    vecs[5]  = mk(10, -3, 1, 0, -270, 0, 0);
    vecs[6]  = mk(7, 4, 1, 1, 252, 252, 0);
    vecs[7]  = mk(8, 4, 0, 0, 288, 255, 1);
    vecs[8]  = mk(-256, 255, 0, 0, -587520, -256, 1);
    vecs[9]  = mk(255, 255, 1, 1, 585225, 255, 1);
    vecs[10] = mk(-2, 14, 0, 1, -252, -252, 0);
    vecs[11] = mk(0, 123, 1, 0, 0, 0, 0);

    reset     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    in_valid  = 1'b0;
    relu_en   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_q_out", q_out, 0);
      check("rst_q_sat", q_sat, 0);
    end
    reset = 1'b1;
    #1;
    check("rel_in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_first_edge", in_ready, 1);

    // Back-to-back windows from the table
    for (int i = 0; i < 12; i++) run_window(vecs[i], 1'b1);

    // Consumer stall in HOLD, with beats offered that must be ignored
    out_ready = 1'b0;
    run_window(vecs[0], 1'b0);
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_in     = DATA_W'(99);
      b_in     = DATA_W'(99);
      cyc();
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, held);
      check("stall_q_out", q_out, 108);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("stall_release", out_valid, 0);
    run_window(mk(1, 1, 0, 0, 9, 9, 0), 1'b1);

    // Flush after four beats, beat in the flush cycle is dropped
    send_beats(4, DATA_W'(50), DATA_W'(50), 1'b0, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    a_in     = DATA_W'(100);
    b_in     = DATA_W'(100);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    run_window(mk(1, 2, 0, 0, 18, 18, 0), 1'b1);

    // Flush while a result is held discards it
    out_ready = 1'b0;
    run_window(mk(2, 5, 0, 0, 90, 90, 0), 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_hold_out_valid", out_valid, 0);
    check("flush_hold_result", result, 0);
    cyc();
    check("flush_hold_stays_clear", out_valid, 0);
    out_ready = 1'b1;
    run_window(mk(-1, 3, 0, 1, -27, -27, 0), 1'b1);

    // Asynchronous reset mid-window
    send_beats(4, DATA_W'(5), DATA_W'(5), 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("midrst_no_output", out_valid, 0);
    end
    run_window(mk(2, 2, 0, 0, 36, 36, 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
